// File: rtl/a_seq_driver.sv
// Drives the A line through one high-low-high-low pattern of programmable phase length and
// reports pass/fail from the K2/K1 pulses returned by the receiving controller.
module a_seq_driver #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TO    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] hold_i,
    input  logic             k2_i,
    input  logic             k1_i,
    output logic             a_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned TW = (TO > 1) ? $clog2(TO) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StHi1,
        StLo1,
        StHi2,
        StLo2,
        StWait
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lenm1_q;
    logic [TW-1:0]    tcnt_q;
    logic             a_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             k2_seen_q;
    logic             k1_seen_q;

    logic [CNT_W-1:0] len_new;
    logic             in_window;

    always_comb begin
        len_new   = (hold_i == '0) ? CNT_W'(1) : hold_i;
        in_window = (state_q == StHi2) || (state_q == StLo2) || (state_q == StWait);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            lenm1_q   <= '0;
            tcnt_q    <= '0;
            a_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            k2_seen_q <= 1'b0;
            k1_seen_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Sticky capture of controller responses; only meaningful from the second rise on.
            if (in_window) begin
                if (k2_i) k2_seen_q <= 1'b1;
                if (k1_i) k1_seen_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StHi1;
                        a_q       <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= len_new - CNT_W'(1);
                        lenm1_q   <= len_new - CNT_W'(1);
                        err_q     <= 1'b0;
                        k2_seen_q <= 1'b0;
                        k1_seen_q <= 1'b0;
                    end
                end
                StHi1: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= StLo1;
                        a_q     <= 1'b0;
                        cnt_q   <= lenm1_q;
                    end
                end
                StLo1: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= StHi2;
                        a_q     <= 1'b1;
                        cnt_q   <= lenm1_q;
                    end
                end
                StHi2: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= StLo2;
                        a_q     <= 1'b0;
                        cnt_q   <= lenm1_q;
                    end
                end
                StLo2: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= StWait;
                        a_q     <= 1'b0;
                        tcnt_q  <= TW'(TO - 1);
                    end
                end
                StWait: begin
                    if (k1_seen_q || k1_i) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= !(k2_seen_q || k2_i);
                    end else if (tcnt_q == '0) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q - TW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_o    = a_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule
